// File: rtl/stack_seq_pkg.sv
// Shared definitions for the stack sequencer: operand width, op codes and FSM state encoding.
package stack_seq_pkg;

  localparam int DATA_W = 4;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_POP  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_INC,
    ST_DEC,
    ST_RD,
    ST_CAP,
    ST_RSP
  } state_e;

endpackage

// File: rtl/stack_sequencer.sv
// Expands push/call/pop requests into the stack's write-increment / decrement-read strobe sequences.
// Optional STACK_SEQ_STICKY_ERR_EN adds a sticky error flag that clears only on rst.
module stack_sequencer
  import stack_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic [1:0]        op_code,
  output logic              op_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] pc_in,
  output logic [DATA_W-1:0] stack_data_1_o,
  output logic [DATA_W-1:0] stack_data_2_o,
  output logic              stack_push_o,
  output logic              stack_pop_o,
  output logic              stack_we_o,
  output logic              stack_re_o,
  output logic              stack_mux_sel_o,
  input  logic [DATA_W-1:0] stack_data_i,
  input  logic              full_i,
  input  logic              empty_i,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              err_sticky
);

  // Handshake: an operation is accepted on a rising edge where op_valid && op_ready;
  // op_ready is high only in IDLE, so op_valid in any other state is ignored.

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data1_q, data1_d;
  logic [DATA_W-1:0]   data2_q, data2_d;
  logic                mux_q, mux_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                accept;

  assign accept = op_valid && op_ready;

  always_comb begin
    state_d    = state_q;
    data1_d    = data1_q;
    data2_d    = data2_q;
    mux_d      = mux_q;
    err_d      = err_q;
    rsp_data_d = rsp_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          data1_d = data_in;
          data2_d = pc_in;
          err_d   = 1'b0;
          unique case (op_code)
            OP_PUSH, OP_CALL: begin
              if (full_i) begin
                err_d   = 1'b1;
                state_d = ST_RSP;
              end else begin
                mux_d   = (op_code == OP_CALL);
                state_d = ST_WR;
              end
            end
            OP_POP: begin
              if (empty_i) begin
                err_d   = 1'b1;
                state_d = ST_RSP;
              end else begin
                state_d = ST_DEC;
              end
            end
            default: state_d = ST_RSP;
          endcase
        end
      end
      ST_WR:  state_d = ST_INC;
      ST_INC: state_d = ST_RSP;
      ST_DEC: state_d = ST_RD;
      ST_RD:  state_d = ST_CAP;
      ST_CAP: begin
        // Read data is valid the cycle after the read strobe.
        rsp_data_d = stack_data_i;
        state_d    = ST_RSP;
      end
      ST_RSP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      data1_q    <= '0;
      data2_q    <= '0;
      mux_q      <= 1'b0;
      err_q      <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      data1_q    <= data1_d;
      data2_q    <= data2_d;
      mux_q      <= mux_d;
      err_q      <= err_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Gating with rst keeps every strobe and the ready/response low while reset is held.
  assign op_ready        = !rst && (state_q == ST_IDLE);
  assign stack_we_o      = !rst && (state_q == ST_WR);
  assign stack_push_o    = !rst && (state_q == ST_INC);
  assign stack_pop_o     = !rst && (state_q == ST_DEC);
  assign stack_re_o      = !rst && (state_q == ST_RD);
  assign rsp_valid       = !rst && (state_q == ST_RSP);
  assign rsp_err         = rsp_valid && err_q;
  assign rsp_data        = rsp_data_q;
  assign stack_mux_sel_o = mux_q;
  assign stack_data_1_o  = data1_q;
  assign stack_data_2_o  = data2_q;

`ifdef STACK_SEQ_STICKY_ERR_EN
  logic sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q | rsp_err;
  end

  always_ff @(posedge clk) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end

  assign err_sticky = sticky_q;
`else
  assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: behavioural 16-entry stack peripheral plus a LIFO queue reference model.
module tb_stack_sequencer;
  import stack_seq_pkg::*;

  logic       clk, rst;
  logic       op_valid;
  logic [1:0] op_code;
  logic       op_ready;
  logic [3:0] data_in, pc_in;
  logic [3:0] stack_data_1_o, stack_data_2_o;
  logic       stack_push_o, stack_pop_o, stack_we_o, stack_re_o, stack_mux_sel_o;
  logic [3:0] stack_data_i;
  logic       full_i, empty_i;
  logic       rsp_valid, rsp_err, err_sticky;
  logic [3:0] rsp_data;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];
  logic [3:0] last_pop;
  logic       sticky_model;
  logic       force_full, force_empty;

  logic [3:0] mem [16];
  logic [4:0] sp;
  logic [4:0] strobes;

  assign strobes = {stack_we_o, stack_push_o, stack_pop_o, stack_re_o, rsp_valid};
  assign full_i  = (sp == 5'd16) || force_full;
  assign empty_i = (sp == 5'd0) || force_empty;

  stack_sequencer dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready),
    .data_in(data_in), .pc_in(pc_in),
    .stack_data_1_o(stack_data_1_o), .stack_data_2_o(stack_data_2_o),
    .stack_push_o(stack_push_o), .stack_pop_o(stack_pop_o),
    .stack_we_o(stack_we_o), .stack_re_o(stack_re_o), .stack_mux_sel_o(stack_mux_sel_o),
    .stack_data_i(stack_data_i), .full_i(full_i), .empty_i(empty_i),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .err_sticky(err_sticky)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stack peripheral: pointer addresses next free slot; registered read.
  always @(posedge clk) begin
    if (rst) begin
      sp           <= 5'd0;
      stack_data_i <= 4'h0;
    end else begin
      if (stack_we_o) mem[sp[3:0]] <= stack_mux_sel_o ? stack_data_2_o : stack_data_1_o;
      if (stack_push_o) sp <= sp + 5'd1;
      if (stack_pop_o)  sp <= sp - 5'd1;
      if (stack_re_o)   stack_data_i <= mem[sp[3:0]];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Issue one operation and check its full strobe/response timeline against the model.
  task automatic run_op(input logic [1:0] op, input logic [3:0] d, input logic [3:0] pc);
    logic [4:0] ev[4];
    logic       is_push, is_pop, exp_err, exp_sticky;
    logic [3:0] exp_data;
    int         n, waited;
    waited = 0;
    while (!op_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!op_ready) begin
      errors++;
      $display("FAIL ready_wait op_ready=%b required 1 within 20 cycles", op_ready);
      return;
    end
    is_push  = (op == OP_PUSH) || (op == OP_CALL);
    is_pop   = (op == OP_POP);
    exp_err  = (is_push && (exp_q.size() == 16 || force_full)) ||
               (is_pop && (exp_q.size() == 0 || force_empty));
    exp_data = last_pop;
    ev = '{5'b00000, 5'b00000, 5'b00000, 5'b00000};
    if (is_push && !exp_err) begin
      ev[0] = 5'b10000; ev[1] = 5'b01000; ev[2] = 5'b00001; n = 3;
      exp_q.push_back(op == OP_CALL ? pc : d);
    end else if (is_pop && !exp_err) begin
      ev[0] = 5'b00100; ev[1] = 5'b00010; ev[2] = 5'b00000; ev[3] = 5'b00001; n = 4;
      exp_data = exp_q.pop_back();
      last_pop = exp_data;
    end else begin
      ev[0] = 5'b00001; n = 1;
    end
    if (exp_err) sticky_model = 1'b1;
    op_valid = 1'b1; op_code = op; data_in = d; pc_in = pc;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    data_in  = 4'($urandom);
    pc_in    = 4'($urandom);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      checks++;
      if (strobes !== ev[c]) begin
        errors++;
        $display("FAIL strobes op=%0d cyc=T+%0d got %b exp %b", op, c + 1, strobes, ev[c]);
      end
      if (is_push && !exp_err && c < 2) begin
        checks++;
        if (stack_mux_sel_o !== (op == OP_CALL) ||
            (op == OP_PUSH && stack_data_1_o !== d) || (op == OP_CALL && stack_data_2_o !== pc)) begin
          errors++;
          $display("FAIL operand cyc=T+%0d got sel=%b d1=%h d2=%h exp sel=%b d=%h pc=%h",
                   c + 1, stack_mux_sel_o, stack_data_1_o, stack_data_2_o, op == OP_CALL, d, pc);
        end
      end
      if (c == n - 1) begin
        checks++;
        if (rsp_err !== exp_err || rsp_data !== exp_data) begin
          errors++;
          $display("FAIL response op=%0d got err=%b data=%h exp err=%b data=%h",
                   op, rsp_err, rsp_data, exp_err, exp_data);
        end
      end
    end
    @(negedge clk);
`ifdef STACK_SEQ_STICKY_ERR_EN
    exp_sticky = sticky_model;
`else
    exp_sticky = 1'b0;
`endif
    checks++;
    if (op_ready !== 1'b1 || strobes !== 5'b00000 || err_sticky !== exp_sticky) begin
      errors++;
      $display("FAIL idle_return got ready=%b strobes=%b sticky=%b exp 1 00000 %b",
               op_ready, strobes, err_sticky, exp_sticky);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({op_ready, stack_data_1_o, stack_data_2_o, strobes, stack_mux_sel_o,
         rsp_data, rsp_err, err_sticky} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs ready=%b d1=%h d2=%h strobes=%b sel=%b data=%h err=%b sticky=%b exp all 0",
               op_ready, stack_data_1_o, stack_data_2_o, strobes, stack_mux_sel_o, rsp_data, rsp_err, err_sticky);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (op_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release op_ready=%b exp 1", op_ready);
    end
    exp_q.delete();
    last_pop     = 4'h0;
    sticky_model = 1'b0;
  endtask

  task automatic test_push_call_pop();
    run_op(OP_PUSH, 4'hA, 4'h3);
    run_op(OP_CALL, 4'h9, 4'h5);
    run_op(OP_POP, 4'h0, 4'h0);
    run_op(OP_POP, 4'h0, 4'h0);
    run_op(OP_NOP, 4'h6, 4'h6);
  endtask

  task automatic test_lifo_order();
    for (int i = 1; i <= 3; i++) run_op(OP_PUSH, 4'(i), 4'hF);
    repeat (3) run_op(OP_POP, 4'h0, 4'h0);
  endtask

  task automatic test_errors();
    run_op(OP_POP, 4'h0, 4'h0);
    force_full = 1'b1;
    run_op(OP_PUSH, 4'hC, 4'h0);
    run_op(OP_CALL, 4'h0, 4'hD);
    force_full = 1'b0;
    for (int i = 0; i < 16; i++) run_op(($urandom_range(0, 1) != 0) ? OP_CALL : OP_PUSH,
                                        4'($urandom), 4'($urandom));
    run_op(OP_PUSH, 4'h1, 4'h1);
    for (int i = 0; i < 16; i++) run_op(OP_POP, 4'h0, 4'h0);
    run_op(OP_POP, 4'h0, 4'h0);
  endtask

  // op_valid held high across a PUSH while op_code switches to POP.
  task automatic test_back_to_back();
    logic [4:0] ev[9];
    ev = '{5'b10000, 5'b01000, 5'b00001, 5'b00000, 5'b00100, 5'b00010, 5'b00000, 5'b00001, 5'b00000};
    op_valid = 1'b1; op_code = OP_PUSH; data_in = 4'h7; pc_in = 4'h2;
    @(posedge clk);
    #1;
    op_code = OP_POP;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c == 4) op_valid = 1'b0;
      checks++;
      if (strobes !== ev[c]) begin
        errors++;
        $display("FAIL b2b_strobes cyc=T+%0d got %b exp %b", c + 1, strobes, ev[c]);
      end
      if (c == 3 || c == 8) begin
        checks++;
        if (op_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready cyc=T+%0d got %b exp 1", c + 1, op_ready);
        end
      end
      if (c == 7) begin
        checks++;
        if (rsp_data !== 4'h7 || rsp_err !== 1'b0) begin
          errors++;
          $display("FAIL b2b_rsp got data=%h err=%b exp 7 0", rsp_data, rsp_err);
        end
      end
    end
    last_pop = 4'h7;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (strobes !== 5'b00000) begin
        errors++;
        $display("FAIL b2b_single_accept got strobes=%b exp 00000", strobes);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++)
      run_op(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom));
  endtask

  task automatic test_reset_mid_pop();
    run_op(OP_PUSH, 4'h4, 4'h0);
    run_op(OP_PUSH, 4'h8, 4'h0);
    op_valid = 1'b1; op_code = OP_POP;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (strobes !== 5'b00010) begin
      errors++;
      $display("FAIL rd_phase got strobes=%b exp 00010", strobes);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (strobes !== 5'b00000 || op_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort got strobes=%b ready=%b exp 00000 0", strobes, op_ready);
    end
    rst = 1'b0;
    exp_q.delete();
    last_pop     = 4'h0;
    sticky_model = 1'b0;
    @(negedge clk);
    checks++;
    if (op_ready !== 1'b1 || strobes !== 5'b00000 || rsp_data !== 4'h0 || err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL after_abort got ready=%b strobes=%b data=%h sticky=%b exp 1 00000 0 0",
               op_ready, strobes, rsp_data, err_sticky);
    end
    run_op(OP_POP, 4'h0, 4'h0);
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_code = OP_NOP; data_in = 4'h0; pc_in = 4'h0;
    force_full = 1'b0; force_empty = 1'b0;
    last_pop = 4'h0; sticky_model = 1'b0;
    test_reset();
    test_push_call_pop();
    test_lifo_order();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_mid_pop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_sequencer.md
# stack_sequencer

Control-side master for the 16-entry, 4-bit LIFO return/data stack. Accepts single-cycle-handshaked operations (push data, call = push PC, pop/return) from the core. Expands each into the multi-cycle write/increment or decrement/read strobe sequence the stack expects, and returns popped data with a response pulse. Sits between the instruction decoder and the stack top level. It owns every stack control strobe and both stack data inputs.

## Interface
Parameters:
- none. Widths are fixed by the stack: data/PC 4 bits.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- op_valid  in  1  operation request
- op_code  in  2  00 NOP, 01 PUSH (data_in), 10 CALL (pc_in), 11 POP/RET
- op_ready  out  1  high only in IDLE
- data_in  in  4  push operand, sampled at accept
- pc_in  in  4  call operand, sampled at accept
- stack_data_1_o  out  4  registered data operand to stack (mux_sel=0 path)
- stack_data_2_o  out  4  registered PC operand to stack (mux_sel=1 path)
- stack_push_o / stack_pop_o / stack_we_o / stack_re_o  out  1 each  stack strobes, one-cycle pulses
- stack_mux_sel_o  out  1  0 = data, 1 = PC
- stack_data_i  in  4  stack read data, valid the cycle after stack_re_o
- full_i / empty_i  in  1  stack status
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  4  popped value; holds until the next POP completes
- rsp_err  out  1  qualifies rsp_valid; overflow/underflow
- err_sticky  out  1  see Configuration

## Operation
- Stack contract: the pointer addresses the next free slot. Push means write at the pointer, then increment. Pop means decrement, then read.
- Accept: op_valid && op_ready at a rising edge. Operands are latched into stack_data_1_o/stack_data_2_o.
- FSM states: IDLE, WR, INC, DEC, RD, CAP, RSP.
- PUSH/CALL, not full: IDLE→WR (we=1, mux_sel=0 for PUSH, 1 for CALL)→INC (push=1, mux_sel held)→RSP→IDLE.
- POP, not empty: IDLE→DEC (pop=1)→RD (re=1)→CAP (rsp_data<=stack_data_i)→RSP→IDLE.
- Push while full_i, or pop while empty_i, at accept: IDLE→RSP with rsp_err=1. No stack strobe is issued and the stack is untouched.
- NOP: IDLE→RSP, rsp_err=0.
- RSP: rsp_valid=1 for one cycle; op_ready=0.
- At most one strobe is high in any cycle. we and push are never asserted together.
- op_valid outside IDLE is ignored; the requester holds it until accepted.
- Reset value of every output is 0: op_ready=0 during rst and 1 the cycle after. State=IDLE.
- rst mid-sequence aborts at the next edge. Strobes drop immediately and no rsp_valid is produced. The stack is reset in parallel by the same rst.

## Timing
- Accept at edge T.
- PUSH/CALL: we high in cycle T+1, push high in T+2, rsp_valid in T+3, op_ready in T+4.
- POP: pop high in T+1, re high in T+2, data captured at end of T+3, rsp_valid and rsp_data valid in T+4, op_ready in T+5.
- Error/NOP: rsp_valid in T+1, op_ready in T+2.
- full_i/empty_i are sampled only at accept.

## Configuration
- STACK_SEQ_STICKY_ERR_EN defined: err_sticky sets on any rsp_err pulse and clears only on rst.
- Not defined: err_sticky is tied 0 and no sticky register exists.
- rsp_err behaviour is identical in both builds.

## Structure
- Shared package stack_seq_pkg holds:
  - the op_code localparams (OP_NOP, OP_PUSH, OP_CALL, OP_POP)
  - the FSM state encoding
  - DATA_W=4
- Single module; no sub-module is needed. The FSM, operand registers and response register are all in stack_sequencer.

## Test plan
- Reset, then PUSH data_in=0xA: we at T+1 with mux_sel=0 and stack_data_1_o=0xA, push at T+2, rsp_valid at T+3, rsp_err=0.
- CALL pc_in=0x5 then POP: mux_sel=1 during WR/INC. The POP gives rsp_data=0x5 at T+4.
- Push 0x1,0x2,0x3, then pop three times: rsp_data sequence 0x3,0x2,0x1.
- POP with empty_i=1 → rsp_valid and rsp_err at T+1, zero strobes. PUSH with full_i=1 gives the same response. err_sticky=1 only when the macro is defined.
- Assert rst during RD of a POP → all strobes 0 next cycle, no rsp_valid, op_ready=1 the cycle after rst drops.
- op_valid held high during a PUSH sequence with op_code changed → ignored until IDLE, then accepted once.
